// File: rtl/sc_ctrl_pkg.sv
// rtl/sc_ctrl_pkg.sv - shared types for the stack-counter controller
// Contents: sc_op_t (stack ops, legacy encodings), sc_fault_t (latched fault cause),
//           sc_state_t (RUN/FAULT, used only when SC_GUARD_EN is defined).
package sc_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ADV_1 = 2'd1,
        DES_1 = 2'd2,
        DES_2 = 2'd3
    } sc_op_t;

    typedef enum logic [1:0] {
        F_NONE    = 2'd0,
        F_OVF     = 2'd1,
        F_UNF     = 2'd2,
        F_BADLOAD = 2'd3
    } sc_fault_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } sc_state_t;

endpackage

// File: rtl/sc_ctrl_if.sv
// rtl/sc_ctrl_if.sv - decoder-side bundle of the stack-counter controller
// Parameter: SC_W pointer width.
// master (decoder): drives op, load, load_val, clr_fault; observes SC, tos_addr,
//                   nos_addr, empty, full, op_ok, fault, fault_code.
// slave (sc_ctrl):  the mirror image.
interface sc_ctrl_if
    import sc_ctrl_pkg::*;
#(
    parameter int SC_W = 4
);
    sc_op_t            op;
    logic              load;
    logic [SC_W-1:0]   load_val;
    logic              clr_fault;
    logic [SC_W-1:0]   SC;
    logic [SC_W-1:0]   tos_addr;
    logic [SC_W-1:0]   nos_addr;
    logic              empty;
    logic              full;
    logic              op_ok;
    logic              fault;
    sc_fault_t         fault_code;

    modport master (
        output op, load, load_val, clr_fault,
        input  SC, tos_addr, nos_addr, empty, full, op_ok, fault, fault_code
    );

    modport slave (
        input  op, load, load_val, clr_fault,
        output SC, tos_addr, nos_addr, empty, full, op_ok, fault, fault_code
    );
endinterface

// File: rtl/sc_ctrl_guard.sv
// rtl/sc_ctrl_guard.sv - combinational legality check for stack-pointer moves and loads
// Module sc_guard. Parameters: SC_W, DEPTH.
// Inputs:  sc (current pointer), op, load, load_val.
// Outputs: ok (request legal), code (fault cause when not ok, else F_NONE).
module sc_guard
    import sc_ctrl_pkg::*;
#(
    parameter int SC_W  = 4,
    parameter int DEPTH = 15
) (
    input  logic [SC_W-1:0] sc,
    input  sc_op_t          op,
    input  logic            load,
    input  logic [SC_W-1:0] load_val,
    output logic            ok,
    output sc_fault_t       code
);
    localparam logic [SC_W-1:0] DEPTH_V = SC_W'(DEPTH);
    localparam logic [SC_W-1:0] TWO     = SC_W'(2);

    // A load overrides the op, so only the load value is judged when load is set.
    always_comb begin
        ok   = 1'b1;
        code = F_NONE;
        if (load) begin
            if (load_val > DEPTH_V) begin
                ok   = 1'b0;
                code = F_BADLOAD;
            end
        end else begin
            case (op)
                ADV_1: if (sc == DEPTH_V) begin ok = 1'b0; code = F_OVF; end
                DES_1: if (sc == '0)      begin ok = 1'b0; code = F_UNF; end
                DES_2: if (sc < TWO)      begin ok = 1'b0; code = F_UNF; end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sc_ctrl.sv
// rtl/sc_ctrl.sv - parametrised stack-counter controller (pointer, TOS/NOS addresses, status)
// Parameters: SC_W pointer width, DEPTH stack capacity (2..2**SC_W-1).
// Ports: clk, reset (async active-low), bus (sc_ctrl_if.slave: op/load/load_val/clr_fault in;
//        SC/tos_addr/nos_addr/empty/full/op_ok/fault/fault_code out).
// Build option SC_GUARD_EN: when defined, illegal moves/loads are refused and latch a
// sticky fault through a RUN/FAULT FSM; when undefined the pointer wraps freely.
module sc_ctrl
    import sc_ctrl_pkg::*;
#(
    parameter int SC_W  = 4,
    parameter int DEPTH = 15
) (
    input  logic      clk,
    input  logic      reset,
    sc_ctrl_if.slave  bus
);
    localparam logic [SC_W-1:0] DEPTH_V = SC_W'(DEPTH);
    localparam logic [SC_W-1:0] ONE     = SC_W'(1);
    localparam logic [SC_W-1:0] TWO     = SC_W'(2);

    logic [SC_W-1:0] sc;
    logic [SC_W-1:0] sc_step;

    always_comb begin
        sc_step = sc;
        case (bus.op)
            ADV_1:   sc_step = sc + ONE;
            DES_1:   sc_step = sc - ONE;
            DES_2:   sc_step = sc - TWO;
            default: sc_step = sc;
        endcase
    end

    // Address outputs wrap below 1/2 entries; consumers qualify them with empty/SC.
    assign bus.SC       = sc;
    assign bus.tos_addr = sc - ONE;
    assign bus.nos_addr = sc - TWO;
    assign bus.empty    = (sc == '0);
    assign bus.full     = (sc == DEPTH_V);

`ifdef SC_GUARD_EN
    sc_state_t state;
    logic      guard_ok;
    sc_fault_t guard_code;
    logic      fault_q;
    sc_fault_t code_q;

    sc_guard #(.SC_W(SC_W), .DEPTH(DEPTH)) u_guard (
        .sc       (sc),
        .op       (bus.op),
        .load     (bus.load),
        .load_val (bus.load_val),
        .ok       (guard_ok),
        .code     (guard_code)
    );

    assign bus.op_ok      = (state == RUN) && guard_ok;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

    // clr_fault outranks load/op; an illegal request freezes SC and parks in FAULT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc      <= '0;
            state   <= RUN;
            fault_q <= 1'b0;
            code_q  <= F_NONE;
        end else if (bus.clr_fault) begin
            state   <= RUN;
            fault_q <= 1'b0;
            code_q  <= F_NONE;
        end else if (state == RUN) begin
            if (!guard_ok) begin
                state   <= FAULT;
                fault_q <= 1'b1;
                code_q  <= guard_code;
            end else if (bus.load) begin
                sc <= bus.load_val;
            end else begin
                sc <= sc_step;
            end
        end
    end
`else
    logic unused_clr_fault;
    assign unused_clr_fault = bus.clr_fault;

    assign bus.op_ok      = 1'b1;
    assign bus.fault      = 1'b0;
    assign bus.fault_code = F_NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc <= '0;
        end else if (bus.load) begin
            sc <= bus.load_val;
        end else begin
            sc <= sc_step;
        end
    end
`endif
endmodule

// File: tb/tb_sc_ctrl.sv
// tb/tb_sc_ctrl.sv - directed self-checking bench for sc_ctrl (guarded or unguarded build)
module tb_sc_ctrl;
    import sc_ctrl_pkg::*;

`ifdef SC_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sc_ctrl_if #(.SC_W(4)) ba ();
    sc_ctrl_if #(.SC_W(6)) bb ();

    sc_ctrl #(.SC_W(4), .DEPTH(15)) dut_a (.clk(clk), .reset(rst_n), .bus(ba));
    sc_ctrl #(.SC_W(6), .DEPTH(40)) dut_b (.clk(clk), .reset(rst_n), .bus(bb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input sc_op_t op, input logic ld, input logic [3:0] lv, input logic cf);
        ba.op        = op;
        ba.load      = ld;
        ba.load_val  = lv;
        ba.clr_fault = cf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_a(HOLD, 1'b0, 4'd0, 1'b0);
        bb.op = HOLD; bb.load = 1'b0; bb.load_val = '0; bb.clr_fault = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_sc",    32'(ba.SC), 0);
        chk("rst_tos",   32'(ba.tos_addr), 15);
        chk("rst_nos",   32'(ba.nos_addr), 14);
        chk("rst_empty", 32'(ba.empty), 1);
        chk("rst_full",  32'(ba.full), 0);
        chk("rst_fault", 32'(ba.fault), 0);
        chk("rst_code",  32'(ba.fault_code), 32'(F_NONE));
        chk("rst_opok",  32'(ba.op_ok), 1);
        chk("rst_b_tos", 32'(bb.tos_addr), 63);
        rst_n = 1'b1;

        drive_a(ADV_1, 1'b0, 4'd0, 1'b0);
        repeat (3) tick();
        chk("adv3_sc",    32'(ba.SC), 3);
        chk("adv3_tos",   32'(ba.tos_addr), 2);
        chk("adv3_nos",   32'(ba.nos_addr), 1);
        chk("adv3_empty", 32'(ba.empty), 0);

        // asynchronous reset mid-cycle
        drive_a(HOLD, 1'b0, 4'd0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_sc", 32'(ba.SC), 0);
        #2 rst_n = 1'b1;
        tick();

        drive_a(HOLD, 1'b1, 4'd15, 1'b0);
        tick();
        chk("ld15_sc",   32'(ba.SC), 15);
        chk("ld15_full", 32'(ba.full), 1);

        drive_a(ADV_1, 1'b0, 4'd0, 1'b0);
        #1;
        chk("ovf_opok", 32'(ba.op_ok), G ? 0 : 1);
        tick();
        chk("ovf_sc",    32'(ba.SC), G ? 15 : 0);
        chk("ovf_full",  32'(ba.full), G ? 1 : 0);
        chk("ovf_fault", 32'(ba.fault), G ? 1 : 0);
        chk("ovf_code",  32'(ba.fault_code), G ? 32'(F_OVF) : 32'(F_NONE));

        drive_a(HOLD, 1'b0, 4'd0, 1'b1);
        tick();
        chk("clr1_fault", 32'(ba.fault), 0);
        chk("clr1_code",  32'(ba.fault_code), 32'(F_NONE));

        drive_a(HOLD, 1'b1, 4'd1, 1'b0);
        tick();
        chk("ld1_sc", 32'(ba.SC), 1);

        drive_a(DES_2, 1'b0, 4'd0, 1'b0);
        #1;
        chk("unf2_opok", 32'(ba.op_ok), G ? 0 : 1);
        tick();
        chk("unf2_sc",   32'(ba.SC), G ? 1 : 15);
        chk("unf2_code", 32'(ba.fault_code), G ? 32'(F_UNF) : 32'(F_NONE));

        drive_a(DES_1, 1'b0, 4'd0, 1'b0);
        #1;
        chk("faulted_opok", 32'(ba.op_ok), G ? 0 : 1);
        tick();
        chk("faulted_sc", 32'(ba.SC), G ? 1 : 14);

        drive_a(HOLD, 1'b0, 4'd0, 1'b1);
        tick();
        chk("clr2_fault", 32'(ba.fault), 0);
        drive_a(HOLD, 1'b1, 4'd1, 1'b0);
        tick();
        drive_a(DES_1, 1'b0, 4'd0, 1'b0);
        tick();
        chk("des1_sc",    32'(ba.SC), 0);
        chk("des1_empty", 32'(ba.empty), 1);

        drive_a(ADV_1, 1'b1, 4'd9, 1'b0);
        tick();
        chk("ld9_adv_sc", 32'(ba.SC), 9);

        drive_a(HOLD, 1'b1, 4'd0, 1'b0);
        tick();
        drive_a(DES_1, 1'b0, 4'd0, 1'b1);
        tick();
        chk("clr_unf_fault", 32'(ba.fault), 0);
        chk("clr_unf_code",  32'(ba.fault_code), 32'(F_NONE));
        chk("clr_unf_sc",    32'(ba.SC), G ? 0 : 15);
        drive_a(HOLD, 1'b0, 4'd0, 1'b0);

        // wide instance: SC_W=6, DEPTH=40
        bb.op = ADV_1;
        repeat (40) tick();
        chk("b_adv40_sc",   32'(bb.SC), 40);
        chk("b_adv40_full", 32'(bb.full), 1);
        chk("b_adv41_opok", 32'(bb.op_ok), G ? 0 : 1);
        bb.op = DES_2;
        repeat (20) tick();
        chk("b_des2x20_sc",    32'(bb.SC), 0);
        chk("b_des2x20_empty", 32'(bb.empty), 1);

        bb.op = HOLD; bb.load = 1'b1; bb.load_val = 6'd41;
        #1;
        chk("b_badld_opok", 32'(bb.op_ok), G ? 0 : 1);
        tick();
        chk("b_badld_sc",    32'(bb.SC), G ? 0 : 41);
        chk("b_badld_fault", 32'(bb.fault), G ? 1 : 0);
        chk("b_badld_code",  32'(bb.fault_code), G ? 32'(F_BADLOAD) : 32'(F_NONE));
        bb.load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_ctrl.md
# sc_ctrl

Parametrised stack-counter controller for the stack machine datapath: the successor of the fixed 4-bit stack counter. It keeps the stack pointer and derives top-of-stack and next-of-stack addresses for the operand memory. It adds full/empty status, a direct pointer load for frame restore, and a guarded mode that refuses illegal moves and latches a sticky fault. It sits between the decoder (which issues stack ops) and the stack memory/reg_file address ports.

## Interface
- SC_W, 4, pointer width in bits
- DEPTH, 15, stack capacity in entries; legal range 2..2**SC_W-1
- clk  in  1  rising-edge clock; pointer, FSM and fault registers update on it
- reset  in  1  asynchronous, active-low; forces pointer to 0, FSM to RUN, fault clear
- op  in  2  sc_op_t: HOLD, ADV_1, DES_1, DES_2
- load  in  1  load pointer from load_val this cycle
- load_val  in  SC_W  new pointer value
- clr_fault  in  1  clear sticky fault, return to RUN
- SC  out  SC_W  current stack pointer (entries in use)
- tos_addr  out  SC_W  SC-1, top-of-stack address
- nos_addr  out  SC_W  SC-2, next-of-stack address
- empty  out  1  SC==0
- full  out  1  SC==DEPTH
- op_ok  out  1  current op/load is legal this cycle
- fault  out  1  sticky error flag
- fault_code  out  2  sc_fault_t: F_NONE, F_OVF, F_UNF, F_BADLOAD

## Operation
- Priority per edge: reset > clr_fault > load > op.
- ADV_1: SC+1. DES_1: SC-1. DES_2: SC-2. HOLD: SC unchanged.
- Load: SC <= load_val; op ignored that cycle.
- clr_fault: fault<=0, fault_code<=F_NONE, state<=RUN. Op and load ignored that cycle.
- Legality (guard, see Configuration):
  - ADV_1 illegal at SC==DEPTH (F_OVF).
  - DES_1 illegal at SC==0 (F_UNF).
  - DES_2 illegal at SC<2 (F_UNF).
  - Load illegal when load_val>DEPTH (F_BADLOAD).
- FSM: RUN -> FAULT on an illegal request. In that case SC is unchanged, fault<=1 and fault_code is latched. FAULT -> RUN only on clr_fault or reset.
- In FAULT, op and load are ignored, SC holds and op_ok=0.
- tos_addr/nos_addr are plain SC_W-bit subtractions (wrap when SC<1/<2); consumers qualify them with empty and SC.
- empty, full, tos_addr, nos_addr and op_ok are combinational from the registered SC/state plus current inputs.

## Timing
- Reset values: SC=0, tos_addr=all-ones, nos_addr=all-ones-1, empty=1, full=0, fault=0, fault_code=F_NONE, state=RUN, op_ok reflects inputs.
- Reset assertion takes effect immediately (asynchronous). Deassertion is synchronous to clk at the codebase level.
- Latency: op/load sampled at edge N; new SC and derived flags are valid after edge N.
- An illegal request at edge N produces fault=1 after edge N. SC shows its pre-request value.
- Reset mid-FAULT or mid-sequence returns to the reset values; no pending op survives.
- Back-to-back ops are allowed every cycle; no handshake stall.

## Configuration
- SC_GUARD_EN defined: legality check, RUN/FAULT FSM, fault and fault_code as above.
- SC_GUARD_EN undefined:
  - No checks; SC wraps modulo 2**SC_W on ADV_1/DES_1/DES_2, and loads are taken as-is.
  - fault tied 0, fault_code tied F_NONE, op_ok tied 1, clr_fault ignored, FSM not built.
  - empty/full still computed.

## Structure
- definitions package: sc_op_t (HOLD, ADV_1, DES_1, DES_2, keeping the existing encodings), sc_fault_t, sc_state_t (RUN, FAULT).
- One sub-module, sc_guard: combinational legality check taking SC, op, load, load_val and DEPTH, returning ok and fault code. Instantiated only under SC_GUARD_EN.

## Test plan
- Reset, then ADV_1 x3 -> SC=3, tos_addr=2, nos_addr=1, empty=0. Assert reset low mid-cycle -> SC=0 immediately.
- From SC=15 (DEPTH=15) ADV_1 -> guard: SC stays 15, full=1, fault=1, fault_code=F_OVF. No guard: SC=0.
- SC=1, DES_2 -> guard: SC=1, F_UNF. Then DES_1 while faulted -> SC stays 1. Then clr_fault, then DES_1 -> SC=0, empty=1.
- Load with load_val=9 and simultaneous ADV_1 -> SC=9. load_val=15 accepted. load_val=16 (SC_W=5) -> F_BADLOAD, SC unchanged.
- clr_fault together with an illegal DES_1 at SC=0 -> fault=0, SC=0, no new fault.
- SC_W=6, DEPTH=40: ADV_1 x40 -> full=1, op_ok=0 on next ADV_1. DES_2 x20 -> SC=0.
